// File: rtl/data_mem_responder.sv
// Load/store data memory with LATENCY wait states between request acceptance and a one-cycle ack.
// One transaction in flight; requests are ignored while busy and the latched request drives the access.
module data_mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] LAT = 4'(LATENCY);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mem [0:(2**ADDR_W)-1];

   // With zero latency RESP is entered straight from IDLE, so the access uses the live request.
   logic              sel_wr;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic [ADDR_W-1:0] sel_idx;
   logic              sel_err;
   logic              commit;

   always_comb begin
      sel_wr    = (state_q == S_IDLE) ? wr    : wr_q;
      sel_addr  = (state_q == S_IDLE) ? addr  : addr_q;
      sel_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
      sel_idx   = sel_addr[ADDR_W+1:2];
      sel_err   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_W + 2)) != 32'd0);
      commit    = (state_d == S_RESP) && (state_q != S_RESP) && !reset;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage survives reset; an aborted store never reaches its commit edge.
   always_ff @(posedge clk) begin
      if (commit && sel_wr && !sel_err) begin
         mem[sel_idx] <= sel_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               wr_d    = wr;
               addr_d  = addr;
               wdata_d = wdata;
               if (LAT == 4'd0) begin
                  state_d = S_RESP;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = LAT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      if (commit && !sel_wr && !sel_err) begin
         rdata_d = mem[sel_idx];
      end
   end

   always_comb begin
      ack   = (state_q == S_RESP);
      busy  = (state_q != S_IDLE);
      err   = ack && ((addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0));
      rdata = rdata_q;
   end

endmodule
